// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit:
// FSM state encoding, access-size encoding and default memory depth.
package load_store_unit_pkg;

    localparam int DEPTH_WORDS = 64;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane alignment for the load/store unit: load extract/extend and
// store merge. Ports: size/is_unsigned/offset select the lane; ld_word in,
// ld_data out (extended); st_old + st_data in, st_word out (merged).
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] ld_word,
    input  logic [31:0] st_old,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [4:0]  lane_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        lane_sh = {offset, 3'b000};
        ld_byte = 8'(ld_word >> lane_sh);
        ld_half = offset[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = ld_word;
        st_word = st_old;
        unique case (1'b1)
            size == SZ_BYTE: begin
                ld_data = is_unsigned ? {24'b0, ld_byte}
                                      : {{24{ld_byte[7]}}, ld_byte};
                st_word = (st_old & ~(32'h0000_00FF << lane_sh))
                        | (32'(st_data[7:0]) << lane_sh);
            end
            size == SZ_HALF: begin
                ld_data = is_unsigned ? {16'b0, ld_half}
                                      : {{16{ld_half[15]}}, ld_half};
                st_word = offset[1] ? {st_data, st_old[15:0]}
                                    : {st_old[31:16], st_data};
            end
            default: begin
                ld_data = ld_word;
                st_word = st_old;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, accesses a word
// memory (read-modify-write for byte/half stores) and returns a response.
// Ports: req_* request handshake, rsp_* response handshake, mem_* memory.
module load_store_unit #(
    parameter int DEPTH_WORDS = load_store_unit_pkg::DEPTH_WORDS,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_error,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);
    import load_store_unit_pkg::*;

    lsu_state_e    state_q;
    lsu_state_e    state_d;
    logic          r_write;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_off;
    logic [AW-1:0] r_widx;
    logic [31:0]   r_wdata;
    logic [31:0]   word_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          req_err;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;

    lsu_lane_align u_align (
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .offset      (r_off),
        .ld_word     (mem_rdata),
        .st_old      (word_q),
        .st_data     (r_wdata[15:0]),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_comb begin
        req_err = 1'b0;
        unique case (1'b1)
            req_size == SZ_BYTE: req_err = 1'b0;
            req_size == SZ_HALF: req_err = req_addr[0];
            req_size == SZ_WORD: req_err = |req_addr[1:0];
            default:             req_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))
            req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (req_valid)
                    state_d = req_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS:
                // sub-word stores need the old word before writing
                if (r_write && r_size != SZ_WORD)
                    state_d = ST_MERGE;
                else
                    state_d = ST_RESP;
            ST_MERGE:
                state_d = ST_RESP;
            ST_RESP:
                if (rsp_ready)
                    state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_widx     <= '0;
            r_wdata    <= 32'b0;
            word_q     <= 32'b0;
            rdata_q    <= 32'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE:
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[1:0];
                        r_widx     <= req_addr[AW+1:2];
                        r_wdata    <= req_wdata;
                        rdata_q    <= 32'b0;
                        err_q      <= req_err;
                    end
                ST_ACCESS: begin
                    word_q <= mem_rdata;
                    if (!r_write)
                        rdata_q <= ld_data;
                end
                ST_RESP:
                    if (rsp_ready) begin
                        rdata_q <= 32'b0;
                        err_q   <= 1'b0;
                    end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_error = err_q;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        mem_we    = 1'b0;
        if (state_q == ST_ACCESS) begin
            mem_addr = r_widx;
            if (r_write && r_size == SZ_WORD) begin
                mem_we    = 1'b1;
                mem_wdata = r_wdata;
            end
        end else if (state_q == ST_MERGE) begin
            mem_addr  = r_widx;
            mem_we    = 1'b1;
            mem_wdata = st_word;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 64-word memory model.
// Ports: drives the full request/response interface and memory bus.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic        mem_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int          lat;
    int          we_cnt;
    int          we_at;
    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'b0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    load_store_unit #(.DEPTH_WORDS(64), .AW(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mem_clr = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat    = 1;
        we_cnt = 0;
        we_at  = 0;
        while (!rsp_valid && lat < 10) begin
            if (mem_we) begin
                we_cnt++;
                we_at = lat;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_error;
    endtask

    task automatic rsp_hs();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_lat", lat, 2);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_we_cnt", we_cnt, 1);
        rsp_hs();
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_we_cnt", we_cnt, 0);
        rsp_hs();

        // byte store and sign/zero-extended loads
        do_reset();
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680);
        chk("sb_lat", lat, 3);
        chk("sb_we_cnt", we_cnt, 1);
        rsp_hs();
        chk("sb_mem", mem[4], 32'h8000_0000);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("lb_signed", rd, 32'hFFFF_FF80);
        chk("lb_lat", lat, 2);
        rsp_hs();
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("lbu", rd, 32'h0000_0080);
        rsp_hs();
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        chk("lh_signed", rd, 32'hFFFF_8000);
        rsp_hs();

        // halfword read-modify-write
        do_reset();
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        rsp_hs();
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_AABB);
        chk("sh_lat", lat, 3);
        chk("sh_we_cnt", we_cnt, 1);
        chk("sh_we_in_merge", we_at, 2);
        rsp_hs();
        chk("sh_mem", mem[8], 32'hAABB_3344);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        chk("lh_low", rd, 32'h0000_3344);
        rsp_hs();
        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        chk("lbu_lane3", rd, 32'h0000_00AA);
        rsp_hs();

        // error responses
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        chk("e_half_err", 32'(er), 32'd1);
        chk("e_half_lat", lat, 1);
        chk("e_half_rdata", rd, 32'd0);
        chk("e_half_we", we_cnt, 0);
        rsp_hs();
        do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h5A5A_5A5A);
        chk("e_range_err", 32'(er), 32'd1);
        chk("e_range_lat", lat, 1);
        chk("e_range_we", we_cnt, 0);
        rsp_hs();
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h5A5A_5A5A);
        chk("e_size_err", 32'(er), 32'd1);
        chk("e_size_lat", lat, 1);
        chk("e_size_we", we_cnt, 0);
        rsp_hs();
        chk("e_mem8", mem[8], 32'hAABB_3344);
        chk("e_mem0", mem[0], 32'd0);

        // backpressure with an ignored request in flight
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("bp_first", rd, 32'hAABB_3344);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0;
        req_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hAABB_3344);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_mem_we", 32'(mem_we), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_still_idle", 32'(req_ready), 32'd1);
        chk("bp_mem0", mem[0], 32'd0);

        // reset during MERGE of a byte store
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h21;
        req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ro_access_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        chk("ro_merge_we", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("ro_req_ready", 32'(req_ready), 32'd1);
        chk("ro_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ro_rsp_rdata", rsp_rdata, 32'd0);
        chk("ro_rsp_error", 32'(rsp_error), 32'd0);
        chk("ro_mem_we", 32'(mem_we), 32'd0);
        chk("ro_mem_addr", 32'(mem_addr), 32'd0);
        chk("ro_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("ro_mem8", mem[8], 32'hAABB_3344);
        @(negedge clk);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
